// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
// i2c_slave_regfile
//   I2C target answering one 7-bit address. It exposes a REG_DEPTH x 8 register
//   file. A write transfers a register-pointer byte followed by a burst of data
//   bytes. A read uses a repeated START with R/W=1 and begins at the current
//   pointer. The pointer auto-increments and wraps in both directions.
//   SCL and SDA are oversampled on clk. SDA is driven open-drain (pull low only).
// Ports
//   clk, rst    system clock (>= 8x SCL); asynchronous active-high reset
//   scl_in      bus SCL, asynchronous
//   sda_in      bus SDA, asynchronous
//   sda_oe      1 = pull SDA low, 0 = release
//   wr_stb      1-clk pulse when a bus write updates a register
//   wr_addr     index of that register (valid with wr_stb)
//   wr_data     byte written (valid with wr_stb)
//   busy        high from address match until STOP / return to idle
//   host_addr   local read-back index
//   host_data   reg[host_addr], combinational
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned REG_DEPTH  = 16,
  localparam int unsigned PW        = $clog2(REG_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } state_t;

  // Synchroniser plus history flops. Reset to the idle-bus level so that
  // leaving reset does not produce spurious edges.
  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  state_t        r_state;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_rw;
  logic [PW-1:0] r_ptr;
  logic          r_sda_oe;
  logic          r_wr_stb;
  logic [PW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_busy;
  logic [7:0]    r_regs [REG_DEPTH];

  logic [7:0]    w_byte_in;
  logic [PW-1:0] w_ptr_inc;
  assign w_byte_in = {r_shift[6:0], r_sda_s2};
  assign w_ptr_inc = r_ptr + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      for (int unsigned i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                r_rw     <= r_shift[0];
                r_state  <= S_ADDR_ACK;
              end else begin
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_state  <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= '0;
              if (r_rw) begin
                r_shift  <= r_regs[r_ptr];
                r_sda_oe <= ~r_regs[r_ptr][7];
                r_state  <= S_RDATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_REG;
              end
            end
          end
          S_REG: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) r_ptr <= w_byte_in[PW-1:0];
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_sda_oe <= 1'b1;
              r_state  <= S_REG_ACK;
            end
          end
          S_REG_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= S_WDATA;
            end
          end
          S_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_regs[r_ptr] <= w_byte_in;
                r_wr_stb      <= 1'b1;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_byte_in;
                r_ptr         <= w_ptr_inc;
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_sda_oe <= 1'b1;
              r_state  <= S_WDATA_ACK;
            end
          end
          S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              // cnt==0 only on a follow-on byte: it was loaded at the ACK rise,
              // and its MSB goes out on this first fall.
              if (r_bit_cnt == 4'd0) begin
                r_sda_oe <= ~r_shift[7];
              end else if (r_bit_cnt < 4'd8) begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_RDATA_ACK;
              end
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              r_ptr <= w_ptr_inc;
              if (!r_sda_s2) begin
                r_shift   <= r_regs[w_ptr_inc];
                r_bit_cnt <= '0;
                r_state   <= S_RDATA;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign wr_stb    = r_wr_stb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign host_data = r_regs[host_addr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
// Bench for i2c_slave_regfile: a bus-master model drives SCL/SDA with
// open-drain resolution. Expected register writes are queued and checked by a
// monitor on each wr_stb; bus-level responses are checked where they occur.
module tb_i2c_slave_regfile;
  localparam int Q = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m, sda_bus;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_addr, host_addr;
  logic [7:0] wr_data, host_data;

  always #5 clk = ~clk;
  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .REG_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .host_addr(host_addr), .host_data(host_data)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t  exp_wr[$];
  logic oe_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write scoreboard monitor
  always @(negedge clk) begin
    if (!rst && wr_stb) begin
      if (exp_wr.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wr_unexpected: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", {28'd0, wr_addr}, {28'd0, e.a});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
      end
    end
  end

  always @(posedge clk) if (sda_oe) oe_seen = 1'b1;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic start_cond();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
    end
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
    end
  endtask

  task automatic get_ack(output logic a);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    a = sda_bus;  #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic wb_ack(input logic [7:0] b, input string name);
    logic a;
    send_bits(b, 8);
    get_ack(a);
    check(name, {31'd0, a}, 32'd0);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      b[i] = sda_bus; #Q;
      scl_m = 1'b0; #Q;
    end
    sda_m = nack; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic check_host(input logic [3:0] a, input logic [7:0] exp, input string name);
    host_addr = a;
    #1;
    check(name, {24'd0, host_data}, {24'd0, exp});
  endtask

  initial begin
    logic [7:0] rb;
    logic       a;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_addr = '0; oe_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    for (int i = 0; i < 16; i++) check_host(4'(i), 8'h00, "rst_reg");
    @(negedge clk) rst = 1'b0;
    #(4*Q);

    // 1: single write
    exp_wr.push_back('{a: 4'd3, d: 8'hA5});
    start_cond();
    wb_ack(8'hA0, "t1_addr_ack");
    wb_ack(8'h03, "t1_reg_ack");
    wb_ack(8'hA5, "t1_data_ack");
    check("t1_busy", {31'd0, busy}, 32'd1);
    stop_cond();
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check_host(4'd3, 8'hA5, "t1_reg3");

    // 2: burst with pointer wrap
    exp_wr.push_back('{a: 4'd14, d: 8'h11});
    exp_wr.push_back('{a: 4'd15, d: 8'h22});
    exp_wr.push_back('{a: 4'd0,  d: 8'h33});
    start_cond();
    wb_ack(8'hA0, "t2_addr_ack");
    wb_ack(8'h0E, "t2_reg_ack");
    wb_ack(8'h11, "t2_d0_ack");
    wb_ack(8'h22, "t2_d1_ack");
    wb_ack(8'h33, "t2_d2_ack");
    stop_cond();
    check_host(4'd14, 8'h11, "t2_reg14");
    check_host(4'd15, 8'h22, "t2_reg15");
    check_host(4'd0,  8'h33, "t2_reg0");

    // preload reg4/reg5 so the reads below return distinct values
    exp_wr.push_back('{a: 4'd4, d: 8'h3C});
    exp_wr.push_back('{a: 4'd5, d: 8'h77});
    start_cond();
    wb_ack(8'hA0, "pre_addr_ack");
    wb_ack(8'h04, "pre_reg_ack");
    wb_ack(8'h3C, "pre_d0_ack");
    wb_ack(8'h77, "pre_d1_ack");
    stop_cond();

    // 3: pointer write, repeated START, read ACK then NACK
    start_cond();
    wb_ack(8'hA0, "t3_addr_ack");
    wb_ack(8'h03, "t3_reg_ack");
    start_cond();
    wb_ack(8'hA1, "t3_raddr_ack");
    read_byte(1'b0, rb);
    check("t3_rd0", {24'd0, rb}, 32'hA5);
    read_byte(1'b1, rb);
    check("t3_rd1", {24'd0, rb}, 32'h3C);
    stop_cond();
    check("t3_busy_idle", {31'd0, busy}, 32'd0);
    check("t3_oe_idle", {31'd0, sda_oe}, 32'd0);

    // pointer advanced past the NACKed byte: next read starts at reg5
    start_cond();
    wb_ack(8'hA1, "t3b_raddr_ack");
    read_byte(1'b1, rb);
    check("t3b_rd_ptr_post_inc", {24'd0, rb}, 32'h77);
    stop_cond();

    // read burst wrapping 15 -> 0
    start_cond();
    wb_ack(8'hA0, "t3c_addr_ack");
    wb_ack(8'h0F, "t3c_reg_ack");
    start_cond();
    wb_ack(8'hA1, "t3c_raddr_ack");
    read_byte(1'b0, rb);
    check("t3c_rd15", {24'd0, rb}, 32'h22);
    read_byte(1'b1, rb);
    check("t3c_rd0_wrap", {24'd0, rb}, 32'h33);
    stop_cond();

    // 4: wrong address
    oe_seen = 1'b0;
    start_cond();
    send_bits(8'hA2, 8);
    get_ack(a);
    check("t4_no_ack", {31'd0, a}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    send_bits(8'h55, 8);
    get_ack(a);
    stop_cond();
    check("t4_oe_never", {31'd0, oe_seen}, 32'd0);

    // 5: STOP inside a data byte discards it
    start_cond();
    wb_ack(8'hA0, "t5_addr_ack");
    wb_ack(8'h05, "t5_reg_ack");
    send_bits(8'hF0, 4);
    stop_cond();
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_oe", {31'd0, sda_oe}, 32'd0);
    check_host(4'd5, 8'h77, "t5_reg5_unchanged");

    // 6: reset while acknowledging the address
    start_cond();
    send_bits(8'hA0, 8);
    check("t6_oe_ack", {31'd0, sda_oe}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd1);
    @(negedge clk) rst = 1'b1;
    #1;
    check("t6_rst_oe", {31'd0, sda_oe}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("t6_rst_wr_data", {24'd0, wr_data}, 32'd0);
    for (int i = 0; i < 16; i++) check_host(4'(i), 8'h00, "t6_rst_reg");
    @(negedge clk) rst = 1'b0;
    stop_cond();
    exp_wr.push_back('{a: 4'd7, d: 8'h5A});
    start_cond();
    wb_ack(8'hA0, "t6_addr_ack");
    wb_ack(8'h07, "t6_reg_ack");
    wb_ack(8'h5A, "t6_data_ack");
    stop_cond();
    check_host(4'd7, 8'h5A, "t6_reg7");
    check_host(4'd3, 8'h00, "t6_reg3_cleared");

    #(4*Q);
    check("wr_pending", exp_wr.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
